fetch: RTL and testbench

- Multithreaded instruction fetch stage, directly upstream of decode.
- Holds one PC per hardware thread and selects threads round-robin.
- Issues one synchronous instruction-memory read per cycle and delivers {pc, thread_id, instr} to decode one cycle later, in decode's input format.
- Handles per-thread control-flow redirects and the pipeline stall.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_thread_rr_sel.sv | 28 ++
 rtl/fetch.sv | 138 +++++++++++++
 tb/tb_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the multithreaded fetch stage.
// Holds the decode-facing output bundle, the F1 slot and the NOP word.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

package fetch_pkg;

  localparam int XLEN = `XLEN;
  localparam int IW   = `INSTR_WIDTH;

  // addi x0,x0,0
  localparam logic [IW-1:0] NOP_INSTR = IW'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      tid;
    logic [IW-1:0]   instr;
  } fetch_out_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      tid;
    logic            valid;
  } f1_slot_t;

endpackage

// File: rtl/fetch_thread_rr_sel.sv
// Round-robin thread picker: first enabled thread at or after ptr_i.
// In: thread_en_i, ptr_i. Out: sel_tid_o, any_en_o (sel = ptr_i if none).
module thread_rr_sel #(
  parameter int NUM_THREADS = 8
) (
  input  logic [NUM_THREADS-1:0] thread_en_i,
  input  logic [2:0]             ptr_i,
  output logic [2:0]             sel_tid_o,
  output logic                   any_en_o
);

  logic [2:0] idx;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    sel_tid_o = ptr_i;
    any_en_o  = 1'b0;
    idx       = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      idx = 3'((int'(ptr_i) + i) % NUM_THREADS);
      if (thread_en_i[idx]) begin
        sel_tid_o = idx;
        any_en_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch.sv
// Multithreaded fetch stage: round-robin PC select, 1-cycle imem, F2 reg.
// Ports: stall/enable/redirect in, imem req/addr/rdata, fetch_o+valid out;
// fetch_count_o exists only when FETCH_PERF_CNT_EN is defined.
import fetch_pkg::*;

module fetch #(
  parameter int              NUM_THREADS = 8,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [IW-1:0]   NOP_INSTR   = fetch_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic [NUM_THREADS-1:0] thread_en_i,
  input  logic                   redirect_valid_i,
  input  logic [2:0]             redirect_thread_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic [XLEN-1:0]        imem_addr_o,
  output logic                   imem_req_o,
  input  logic [IW-1:0]          imem_rdata_i,
  output fetch_out_t             fetch_o,
  output logic                   fetch_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]        fetch_count_o
`endif
);

  logic [XLEN-1:0] pc_q [NUM_THREADS];
  logic [XLEN-1:0] pc_d [NUM_THREADS];
  logic [2:0]      ptr_q, ptr_d;
  f1_slot_t        slot_q, slot_d;
  fetch_out_t      out_q, out_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] addr_q;
  logic            req_q;

  logic [2:0]      sel_tid;
  logic            any_en;
  logic            redir;
  logic            redir_slot;
  logic            redir_sel;
  logic [XLEN-1:0] redir_pc;
  logic            redir_unused;

  thread_rr_sel #(
    .NUM_THREADS(NUM_THREADS)
  ) u_sel (
    .thread_en_i(thread_en_i),
    .ptr_i      (ptr_q),
    .sel_tid_o  (sel_tid),
    .any_en_o   (any_en)
  );

  assign redir      = redirect_valid_i
                    && (int'(redirect_thread_i) < NUM_THREADS);
  assign redir_slot = redir && (slot_q.tid == redirect_thread_i);
  assign redir_sel  = redir && (sel_tid == redirect_thread_i);
  assign redir_pc   = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign redir_unused = ^redirect_pc_i[1:0];

  always_comb begin
    pc_d        = pc_q;
    ptr_d       = ptr_q;
    slot_d      = slot_q;
    out_d       = out_q;
    valid_d     = valid_q;
    imem_addr_o = addr_q;
    imem_req_o  = req_q;
    if (!stall_i) begin
      imem_addr_o = pc_q[sel_tid];
      imem_req_o  = any_en;
      valid_d     = slot_q.valid && !redir_slot;
      out_d = '{pc: slot_q.pc, tid: slot_q.tid,
                instr: valid_d ? imem_rdata_i : NOP_INSTR};
      slot_d = '{pc: pc_q[sel_tid], tid: sel_tid,
                 valid: any_en && !redir_sel};
      if (any_en) begin
        pc_d[sel_tid] = pc_q[sel_tid] + XLEN'(4);
        ptr_d = (sel_tid == 3'(NUM_THREADS - 1))
              ? 3'd0 : sel_tid + 3'd1;
      end
    end else if (redir_slot) begin
      // Stalled: memory keeps re-reading; just kill the slot.
      slot_d.valid = 1'b0;
    end
    // Applied last so a same-cycle issue of this thread loses.
    if (redir) begin
      pc_d[redirect_thread_i] = redir_pc;
    end
    if (rst) begin
      imem_addr_o = RESET_PC;
      imem_req_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= RESET_PC;
      end
      ptr_q   <= '0;
      slot_q  <= '{pc: RESET_PC, tid: 3'd0, valid: 1'b0};
      out_q   <= '{pc: RESET_PC, tid: 3'd0, instr: NOP_INSTR};
      valid_q <= 1'b0;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      addr_q  <= imem_addr_o;
      req_q   <= imem_req_o;
    end
  end

  assign fetch_o       = out_q;
  assign fetch_valid_o = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] cnt_q, cnt_d;

  // Counts instructions decode actually takes.
  always_comb begin
    cnt_d = cnt_q + {{(XLEN-1){1'b0}}, valid_q & ~stall_i};
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign fetch_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus random traffic vs a model.
// Model tracks per-thread PCs and in-flight fetches at transaction level.
module tb_fetch;
  import fetch_pkg::*;

  localparam int          NT  = 8;
  localparam logic [31:0] RPC = 32'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic [7:0]  thread_en_i;
  logic        redirect_valid_i;
  logic [2:0]  redirect_thread_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic        imem_req_o;
  logic [31:0] imem_rdata_i;
  fetch_out_t  fetch_o;
  logic        fetch_valid_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_o;
`endif

  always #5 clk = ~clk;

  fetch #(.NUM_THREADS(NT), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .thread_en_i      (thread_en_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_thread_i(redirect_thread_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_addr_o      (imem_addr_o),
    .imem_req_o       (imem_req_o),
    .imem_rdata_i     (imem_rdata_i),
    .fetch_o          (fetch_o),
    .fetch_valid_o    (fetch_valid_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count_o    (fetch_count_o)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Synchronous instruction memory; junk when not requested.
  always @(posedge clk)
    imem_rdata_i <= imem_req_o ? mem(imem_addr_o) : 32'hDEAD_BEEF;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  bit          m_init;
  logic [31:0] m_pc [NT];
  int          m_ptr;
  logic [31:0] m_slot_pc;
  logic [2:0]  m_slot_tid;
  bit          m_slot_v, m_slot_known;
  logic [31:0] m_out_pc, m_out_instr;
  logic [2:0]  m_out_tid;
  bit          m_out_v, m_out_known;
  bit          m_req;
  logic [31:0] m_addr;
  logic [31:0] m_cnt;

  bit          collect;
  fetch_out_t  seen[$];
  int          watch_tid = -1;
  logic [31:0] wq[$];

  function automatic int pick();
    for (int k = 0; k < NT; k++)
      if (thread_en_i[(m_ptr + k) % NT]) return (m_ptr + k) % NT;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_pc[i] = RPC;
    m_ptr = 0;
    m_slot_pc = RPC; m_slot_tid = 3'd0;
    m_slot_v = 0; m_slot_known = 1;
    m_out_pc = RPC; m_out_tid = 3'd0; m_out_instr = NOP;
    m_out_v = 0; m_out_known = 1;
    m_req = 0; m_addr = RPC; m_cnt = 0;
    m_init = 1;
  endtask

  // One clock: check at negedge, advance model, return at posedge+1.
  task automatic tick();
    int          sel;
    bit          hit, e_req;
    logic [31:0] e_addr;
    @(negedge clk);
    hit = redirect_valid_i && (int'(redirect_thread_i) < NT);
    sel = pick();
    if (rst) begin
      e_req = 0; e_addr = RPC;
    end else if (stall_i) begin
      e_req = m_req; e_addr = m_addr;
    end else begin
      e_req  = (sel >= 0);
      e_addr = (sel >= 0) ? m_pc[sel] : m_addr;
    end
    if (m_init) begin
      check("imem_req", imem_req_o, e_req);
      if (e_req || rst) check("imem_addr", imem_addr_o, e_addr);
      check("fetch_valid", fetch_valid_o, m_out_v);
      if (m_out_known)
        check("fetch_o", fetch_o, {m_out_pc, m_out_tid, m_out_instr});
      else
        check("fetch_instr", fetch_o.instr, m_out_instr);
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", fetch_count_o, m_cnt);
`endif
      if (collect && fetch_valid_o && seen.size() < 9)
        seen.push_back(fetch_o);
      if (watch_tid >= 0 && fetch_valid_o
          && int'(fetch_o.tid) == watch_tid)
        wq.push_back(fetch_o.pc);
    end
    if (rst) begin
      model_reset();
    end else if (m_init) begin
      if (m_out_v && !stall_i) m_cnt++;
      if (!stall_i) begin
        m_out_v = m_slot_v && !(hit && redirect_thread_i == m_slot_tid);
        m_out_pc = m_slot_pc;
        m_out_tid = m_slot_tid;
        m_out_known = m_slot_known;
        m_out_instr = m_out_v ? mem(m_slot_pc) : NOP;
        if (sel >= 0) begin
          m_slot_pc = m_pc[sel];
          m_slot_tid = 3'(sel);
          m_slot_v = !(hit && int'(redirect_thread_i) == sel);
          m_slot_known = 1;
          m_pc[sel] = m_pc[sel] + 32'd4;
          m_ptr = (sel + 1) % NT;
        end else begin
          m_slot_v = 0;
          m_slot_known = 0;
        end
        m_req = e_req;
        m_addr = e_addr;
      end else if (hit && redirect_thread_i == m_slot_tid) begin
        m_slot_v = 0;
      end
      if (hit) m_pc[redirect_thread_i] = {redirect_pc_i[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    m_init = 0;
    collect = 0;
    rst = 1; stall_i = 0; thread_en_i = 8'hFF;
    redirect_valid_i = 0; redirect_thread_i = 0; redirect_pc_i = 0;
    run(3);

    // All threads, round robin from reset.
    rst = 0; collect = 1;
    run(14);
    collect = 0;
    check("seen_cnt", seen.size(), 9);
    for (int i = 0; i < seen.size(); i++) begin
      check("rr_tid", seen[i].tid, i % 8);
      check("rr_pc", seen[i].pc, (i < 8) ? 0 : 4);
    end

    // Only threads 0 and 2.
    thread_en_i = 8'b0000_0101;
    run(10);

    // Three-cycle stall mid-stream.
    thread_en_i = 8'hFF;
    run(4);
    stall_i = 1;
    run(3);
    stall_i = 0;
    run(6);

    // Redirect thread 3 on the cycle it issues.
    for (int i = 0; i < 16 && pick() != 3; i++) tick();
    redirect_valid_i = 1; redirect_thread_i = 3;
    redirect_pc_i = 32'h0000_0102;
    tick();
    redirect_valid_i = 0;
    wq.delete(); watch_tid = 3;
    run(20);
    watch_tid = -1;
    check("t3_cnt", wq.size() >= 1, 1);
    if (wq.size() >= 1) check("t3_pc", wq[0], 32'h0000_0100);

    // PC wrap on thread 1.
    redirect_valid_i = 1; redirect_thread_i = 1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_valid_i = 0;
    wq.delete(); watch_tid = 1;
    run(24);
    watch_tid = -1;
    check("t1_cnt", wq.size() >= 2, 1);
    if (wq.size() >= 2) begin
      check("t1_pc0", wq[0], 32'hFFFF_FFFC);
      check("t1_pc1", wq[1], 32'h0000_0000);
    end

    // Random traffic including stalls, redirects and resets.
    for (int i = 0; i < 800; i++) begin
      thread_en_i = ($urandom_range(0, 9) == 0) ? 8'h00
                  : 8'($urandom);
      stall_i = ($urandom_range(0, 4) == 0);
      redirect_valid_i = ($urandom_range(0, 5) == 0);
      redirect_thread_i = 3'($urandom);
      redirect_pc_i = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
